platform_scroller: RTL and testbench

Parametrised side-scrolling map engine: holds a runtime-loadable table of platform segments and a frame-rate camera (`left_bound`) that follows the player with a bounded step, clamped to the map edges. After each camera update it scans the table to produce ground/ceiling heights under and beside the player for the collision logic. It also answers per-pixel `is_platform` queries for the color mapper. It sits between the player/character module and the color mapper.

---
 rtl/platform_scroller.sv | 203 ++++++++++++++++++++
 tb/tb_platform_scroller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/platform_scroller.sv
// rtl/platform_scroller.sv - side-scrolling map engine: segment table, camera, ground probes, pixel lookup
module platform_scroller #(
  parameter int NUM_SEG  = 8,
  parameter int COORD_W  = 14,
  parameter int MAP_LEN  = 4479,
  parameter int SCREEN_W = 640,
  parameter int CENTER   = 320,
  parameter int MAX_STEP = 6,
  parameter int HALF_W   = 15,
  localparam int IDX_W   = $clog2(NUM_SEG)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic               cam_en,
  input  logic [COORD_W-1:0] player_x,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [COORD_W-1:0] cfg_x,
  input  logic [9:0]         cfg_top,
  input  logic [9:0]         cfg_bot,
  output logic [COORD_W-1:0] left_bound,
  output logic [9:0]         screen_x,
  output logic [9:0]         top,
  output logic [9:0]         bot,
  output logic [9:0]         top_left,
  output logic [9:0]         top_right,
  output logic               probe_valid,
  output logic               busy,
  output logic               is_platform,
  output logic               cfg_err,
  output logic               frame_overrun
);

  localparam logic [COORD_W-1:0] CENTER_C   = COORD_W'(CENTER);
  localparam logic [COORD_W-1:0] MAX_LEFT_C = COORD_W'(MAP_LEN - SCREEN_W + 1);
  localparam logic [COORD_W-1:0] STEP_C     = COORD_W'(MAX_STEP);
  localparam logic [COORD_W-1:0] HALF_C     = COORD_W'(HALF_W);
  localparam logic [COORD_W-1:0] MAP_LEN_C  = COORD_W'(MAP_LEN);
  localparam logic [COORD_W-1:0] SCRMAX_C   = COORD_W'(SCREEN_W - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_SEG - 1);

  typedef enum logic [1:0] {IDLE, CAM, SCAN, DONE} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               fclk_q, tick_q;
  logic [COORD_W-1:0] seg_x_q   [NUM_SEG];
  logic [9:0]         seg_top_q [NUM_SEG];
  logic [9:0]         seg_bot_q [NUM_SEG];
  logic [COORD_W-1:0] px_q, left_bound_q, left_bound_d, target_d;
  logic [9:0]         screen_x_q, screen_x_d;
  logic [9:0]         top_q, bot_q, tl_q, tr_q;
  logic [9:0]         acc_top_q, acc_bot_q, acc_tl_q, acc_tr_q;
  logic               probe_valid_q, cfg_err_q, overrun_q, is_platform_q;
  logic [COORD_W-1:0] probe_l, probe_r;
  logic [COORD_W:0]   sum_r, mapx;
  logic [9:0]         pix_top, pix_bot;

  assign busy          = (state_q != IDLE);
  assign left_bound    = left_bound_q;
  assign screen_x      = screen_x_q;
  assign top           = top_q;
  assign bot           = bot_q;
  assign top_left      = tl_q;
  assign top_right     = tr_q;
  assign probe_valid   = probe_valid_q;
  assign cfg_err       = cfg_err_q;
  assign frame_overrun = overrun_q;
  assign is_platform   = is_platform_q;

  // Rising-edge detect on the frame clock level
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fclk_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      fclk_q <= frame_clk;
      tick_q <= frame_clk && !fclk_q;
    end
  end

  // Segment table; loads only while idle so a scan always sees a stable table
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_SEG; i++) begin
        seg_x_q[i]   <= '1;
        seg_top_q[i] <= '0;
        seg_bot_q[i] <= '0;
      end
      seg_x_q[0]   <= '0;
      seg_top_q[0] <= 10'd300;
      seg_bot_q[0] <= 10'd350;
    end else if (cfg_we && !busy) begin
      seg_x_q[cfg_idx]   <= (cfg_idx == '0) ? '0 : cfg_x;
      seg_top_q[cfg_idx] <= cfg_top;
      seg_bot_q[cfg_idx] <= cfg_bot;
    end
  end

  // Camera target, bounded step toward it, and resulting player screen column
  always_comb begin
    target_d = (player_x < CENTER_C) ? '0 : player_x - CENTER_C;
    if (target_d > MAX_LEFT_C) target_d = MAX_LEFT_C;
    left_bound_d = left_bound_q;
    if (cam_en) begin
      if (target_d > left_bound_q)
        left_bound_d = (target_d - left_bound_q > STEP_C) ? left_bound_q + STEP_C : target_d;
      else
        left_bound_d = (left_bound_q - target_d > STEP_C) ? left_bound_q - STEP_C : target_d;
    end
    if (player_x < left_bound_d)
      screen_x_d = '0;
    else if (player_x - left_bound_d > SCRMAX_C)
      screen_x_d = 10'(SCREEN_W - 1);
    else
      screen_x_d = 10'(player_x - left_bound_d);
  end

  // Side probes around the latched player position, saturated to the map
  always_comb begin
    probe_l = (px_q >= HALF_C) ? px_q - HALF_C : '0;
    sum_r   = {1'b0, px_q} + {1'b0, HALF_C};
    probe_r = (sum_r > {1'b0, MAP_LEN_C}) ? MAP_LEN_C : sum_r[COORD_W-1:0];
  end

  // Segment containing the pixel's map column; highest matching entry wins
  always_comb begin
    mapx    = {{(COORD_W - 9){1'b0}}, DrawX} + {1'b0, left_bound_q};
    pix_top = seg_top_q[0];
    pix_bot = seg_bot_q[0];
    for (int i = 1; i < NUM_SEG; i++) begin
      if ({1'b0, seg_x_q[i]} <= mapx) begin
        pix_top = seg_top_q[i];
        pix_bot = seg_bot_q[i];
      end
    end
  end

  // Registered pixel hit for the color mapper
  always_ff @(posedge Clk) begin
    if (Reset) is_platform_q <= 1'b0;
    else       is_platform_q <= (mapx <= {1'b0, MAP_LEN_C}) && (DrawY >= pix_top) && (DrawY <= pix_bot);
  end

  // Frame sequencer: camera update, linear table scan, publish probe results
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      px_q          <= '0;
      left_bound_q  <= '0;
      screen_x_q    <= '0;
      acc_top_q     <= 10'd300;
      acc_bot_q     <= 10'd350;
      acc_tl_q      <= 10'd300;
      acc_tr_q      <= 10'd300;
      top_q         <= 10'd300;
      bot_q         <= 10'd350;
      tl_q          <= 10'd300;
      tr_q          <= 10'd300;
      probe_valid_q <= 1'b0;
      cfg_err_q     <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      probe_valid_q <= 1'b0;
      cfg_err_q     <= cfg_we && busy;
      if (tick_q && busy) overrun_q <= 1'b1;
      case (state_q)
        IDLE: if (tick_q) state_q <= CAM;
        CAM: begin
          px_q         <= player_x;
          left_bound_q <= left_bound_d;
          screen_x_q   <= screen_x_d;
          idx_q        <= '0;
          state_q      <= SCAN;
        end
        SCAN: begin
          if (seg_x_q[idx_q] <= px_q) begin
            acc_top_q <= seg_top_q[idx_q];
            acc_bot_q <= seg_bot_q[idx_q];
          end
          if (seg_x_q[idx_q] <= probe_l) acc_tl_q <= seg_top_q[idx_q];
          if (seg_x_q[idx_q] <= probe_r) acc_tr_q <= seg_top_q[idx_q];
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) state_q <= DONE;
        end
        DONE: begin
          top_q         <= acc_top_q;
          bot_q         <= acc_bot_q;
          tl_q          <= acc_tl_q;
          tr_q          <= acc_tr_q;
          probe_valid_q <= 1'b1;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_platform_scroller.sv
// tb/tb_platform_scroller.sv - scoreboard bench for platform_scroller against a behavioural map model
module tb_platform_scroller;
  localparam int NS = 8, CW = 14, ML = 4479, SW = 640, CEN = 320, MS = 6, HW = 15, IW = 3;
  localparam int SENT = (1 << CW) - 1;

  logic Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0, cam_en = 1'b1;
  logic [CW-1:0] player_x = '0, cfg_x = '0;
  logic [9:0] DrawX = '0, DrawY = '0, cfg_top = '0, cfg_bot = '0;
  logic cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [CW-1:0] left_bound;
  logic [9:0] screen_x, top, bot, top_left, top_right;
  logic probe_valid, busy, is_platform, cfg_err, frame_overrun;

  platform_scroller dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .cam_en(cam_en), .player_x(player_x),
    .DrawX(DrawX), .DrawY(DrawY), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x),
    .cfg_top(cfg_top), .cfg_bot(cfg_bot), .left_bound(left_bound), .screen_x(screen_x),
    .top(top), .bot(bot), .top_left(top_left), .top_right(top_right), .probe_valid(probe_valid),
    .busy(busy), .is_platform(is_platform), .cfg_err(cfg_err), .frame_overrun(frame_overrun)
  );

  always #5 Clk = ~Clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: map table as plain arrays, camera as integer arithmetic
  int m_x[NS], m_top[NS], m_bot[NS];
  int m_lb, m_sx;

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      m_x[i] = SENT; m_top[i] = 0; m_bot[i] = 0;
    end
    m_x[0] = 0; m_top[0] = 300; m_bot[0] = 350;
    m_lb = 0;
  endfunction

  function automatic int seg_of(input int p);
    for (int i = NS - 1; i >= 0; i--) if (m_x[i] <= p) return i;
    return 0;
  endfunction

  function automatic void model_cam(input int px, input bit en);
    int target, d;
    target = (px < CEN) ? 0 : px - CEN;
    if (target > ML - SW + 1) target = ML - SW + 1;
    if (en) begin
      d = target - m_lb;
      if (d > MS) m_lb += MS;
      else if (d < -MS) m_lb -= MS;
      else m_lb = target;
    end
    m_sx = px - m_lb;
    if (m_sx < 0) m_sx = 0;
    if (m_sx > SW - 1) m_sx = SW - 1;
  endfunction

  typedef struct { int lb; int sx; int top; int bot; int tl; int tr; } exp_t;
  exp_t exp_q[$];
  bit   pix_q[$];
  bit   pix_req = 1'b0, pix_chk = 1'b0;
  exp_t mon_e;
  bit   mon_p;

  // Probe monitor: every probe_valid must match the oldest outstanding frame
  always @(negedge Clk) begin
    if (!Reset && probe_valid) begin
      chk("probe_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("left_bound", 32'(left_bound), mon_e.lb);
        chk("screen_x", 32'(screen_x), mon_e.sx);
        chk("top", 32'(top), mon_e.top);
        chk("bot", 32'(bot), mon_e.bot);
        chk("top_left", 32'(top_left), mon_e.tl);
        chk("top_right", 32'(top_right), mon_e.tr);
      end
    end
  end

  always @(posedge Clk) pix_chk <= pix_req;

  // Pixel monitor: one cycle after each request
  always @(negedge Clk) begin
    if (pix_chk) begin
      chk("pix_expected", 32'(pix_q.size() != 0), 1);
      if (pix_q.size() != 0) begin
        mon_p = pix_q.pop_front();
        chk("is_platform", 32'(is_platform), 32'(mon_p));
      end
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_left_bound", 32'(left_bound), 0);
    chk("rst_screen_x", 32'(screen_x), 0);
    chk("rst_top", 32'(top), 300);
    chk("rst_bot", 32'(bot), 350);
    chk("rst_top_left", 32'(top_left), 300);
    chk("rst_top_right", 32'(top_right), 300);
    chk("rst_probe_valid", 32'(probe_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_is_platform", 32'(is_platform), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    chk("rst_frame_overrun", 32'(frame_overrun), 0);
  endtask

  task automatic wr_set(input int idx, input int x, input int t, input int b);
    cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_x = CW'(x); cfg_top = 10'(t); cfg_bot = 10'(b);
    m_x[idx] = (idx == 0) ? 0 : x; m_top[idx] = t; m_bot[idx] = b;
  endtask

  task automatic wr(input int idx, input int x, input int t, input int b);
    wr_set(idx, x, t, b);
    @(negedge Clk);
    cfg_we = 1'b0;
  endtask

  task automatic pix(input int dx, input int dy);
    int mx, s;
    DrawX = 10'(dx); DrawY = 10'(dy);
    mx = dx + m_lb;
    s = seg_of(mx);
    pix_q.push_back((mx <= ML) && (dy >= m_top[s]) && (dy <= m_bot[s]));
    pix_req = 1'b1;
    @(negedge Clk);
    pix_req = 1'b0;
  endtask

  // mode 0 plain, 1 second frame edge mid-scan, 2 write mid-scan, 3 Reset mid-scan
  task automatic issue_tick(input int px, input bit en, input int mode);
    exp_t e;
    int l, r, n;
    bit seen;
    player_x = CW'(px); cam_en = en;
    model_cam(px, en);
    l = (px >= HW) ? px - HW : 0;
    r = (px + HW > ML) ? ML : px + HW;
    e.lb = m_lb; e.sx = m_sx;
    e.top = m_top[seg_of(px)]; e.bot = m_bot[seg_of(px)];
    e.tl = m_top[seg_of(l)]; e.tr = m_top[seg_of(r)];
    exp_q.push_back(e);
    frame_clk = 1'b1;
    seen = 1'b0;
    for (n = 1; n <= 40; n++) begin
      @(negedge Clk);
      if (n == 1) begin
        frame_clk = 1'b0; cfg_we = 1'b0;
        chk("busy_tick_cycle", 32'(busy), 0);
      end
      if (n == 2) chk("busy_cam", 32'(busy), 1);
      if (mode == 1) begin
        if (n == 4) frame_clk = 1'b1;
        if (n == 5) frame_clk = 1'b0;
        if (n == 7) chk("frame_overrun_set", 32'(frame_overrun), 1);
      end
      if (mode == 2) begin
        if (n == 4) begin
          cfg_we = 1'b1; cfg_idx = IW'(1); cfg_x = CW'(20); cfg_top = 10'd50; cfg_bot = 10'd60;
        end
        if (n == 5) begin cfg_we = 1'b0; chk("cfg_err_pulse", 32'(cfg_err), 1); end
        if (n == 6) chk("cfg_err_clear", 32'(cfg_err), 0);
      end
      if (mode == 3 && n == 5) Reset = 1'b1;
      if (mode == 3 && n == 6) begin
        chk_reset_outputs();
        Reset = 1'b0;
        model_reset();
        exp_q.delete();
        return;
      end
      if (probe_valid) begin seen = 1'b1; break; end
    end
    chk("probe_latency", seen ? 32'(n) : 32'(0), NS + 4);
  endtask

  task automatic load_random_table();
    int x;
    bit done;
    x = 0; done = 1'b0;
    wr(0, $urandom_range(1, 4000), $urandom_range(0, 479), $urandom_range(250, 479));
    for (int i = 1; i < NS; i++) begin
      if (!done && $urandom_range(0, 4) == 0) done = 1'b1;
      x += $urandom_range(1, 900);
      if (x > ML) done = 1'b1;
      if (done) wr(i, SENT, 0, 0);
      else begin
        int t;
        t = $urandom_range(0, 479);
        wr(i, x, t, t + $urandom_range(0, 100));
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge Clk);
    chk_reset_outputs();
    Reset = 1'b0;
    @(negedge Clk);

    issue_tick(100, 1'b1, 0);

    wr(1, 400, 400, 450);
    wr(2, 500, 300, 350);
    pix(450, 420);
    pix(450, 460);
    pix(450, 320);
    pix(520, 320);
    issue_tick(410, 1'b1, 0);

    repeat (120) issue_tick(1000, 1'b1, 0);
    chk("lb_settle_680", 32'(left_bound), 680);
    repeat (535) issue_tick(4400, 1'b1, 0);
    chk("lb_settle_3840", 32'(left_bound), 3840);
    pix(639, 320);
    pix(640, 320);
    pix(1023, 320);
    repeat (3) issue_tick($urandom_range(0, ML), 1'b0, 0);
    chk("lb_hold_cam_off", 32'(left_bound), 3840);

    issue_tick(410, 1'b1, 1);
    issue_tick(410, 1'b1, 2);
    issue_tick(410, 1'b1, 0);
    issue_tick(410, 1'b1, 3);
    repeat (20) @(negedge Clk);
    issue_tick(410, 1'b1, 0);
    chk("top_after_reset", 32'(top), 300);

    wr_set(1, 200, 100, 120);
    issue_tick(250, 1'b1, 0);

    repeat (40) begin
      if ($urandom_range(0, 3) == 0) load_random_table();
      issue_tick($urandom_range(0, ML), ($urandom_range(0, 3) != 0), 0);
      repeat (4) pix($urandom_range(0, 1023), $urandom_range(0, 511));
    end

    repeat (3) @(negedge Clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    chk("pixel_queue_drained", 32'(pix_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
